// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, FSM state type and init pattern for reg_file_mp
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

    // Mode 1 packs the decimal digits of idx into nibbles, so reg[25] reads 32'h25.
    function automatic logic [31:0] init_val(input int mode, input int idx);
        if (mode == 1) begin
            return 32'(((idx / 10) << 4) | (idx % 10));
        end
        return 32'h0;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write busy bits for decode hazard stalls
module rf_scoreboard #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clr_a_en_i,
    input  logic [AW-1:0]    clr_a_addr_i,
    input  logic             clr_b_en_i,
    input  logic [AW-1:0]    clr_b_addr_i,
    input  logic             set_en_i,
    input  logic [AW-1:0]    set_addr_i,
    output logic [DEPTH-1:0] busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // A fresh issue outranks a completing write to the same register.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < DEPTH; r++) begin
            if ((clr_a_en_i && clr_a_addr_i == AW'(r)) ||
                (clr_b_en_i && clr_b_addr_i == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (set_en_i && set_addr_i == AW'(r)) begin
                busy_d[r] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port integer register file with init sweep, bypass and scoreboard
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AW        = $clog2(DEPTH),
    parameter int NUM_RD    = 2,
    parameter int INIT_MODE = 1,
    parameter int BYPASS    = 1
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    output logic                   ready_o,
    input  logic [NUM_RD*AW-1:0]   rd_addr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      rd_busy_o,
    input  logic                   wa_en_i,
    input  logic [AW-1:0]          wa_addr_i,
    input  logic [XLEN-1:0]        wa_data_i,
    input  logic                   wb_en_i,
    input  logic [AW-1:0]          wb_addr_i,
    input  logic [XLEN-1:0]        wb_data_i,
    input  logic                   iss_en_i,
    input  logic [AW-1:0]          iss_addr_i,
    output logic                   collide_o
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < DEPTH_W);
    endfunction

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             collide_q, collide_d;
    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0] busy;

    logic ready, wa_ok, wb_ok, iss_ok;

    assign ready   = (state_q == ST_RUN);
    assign ready_o = ready;
    assign wa_ok   = ready && wa_en_i  && addr_ok(wa_addr_i);
    assign wb_ok   = ready && wb_en_i  && addr_ok(wb_addr_i);
    assign iss_ok  = ready && iss_en_i && addr_ok(iss_addr_i);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        collide_d = wa_ok && wb_ok && (wa_addr_i == wb_addr_i);
        if (state_q == ST_INIT) begin
            if (ptr_q == AW'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= ST_INIT;
            ptr_q     <= '0;
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            collide_q <= collide_d;
        end
    end

    assign collide_o = collide_q;

    // Port B is written last so it wins when both ports target one register.
    always_ff @(posedge clock_i) begin
        if (state_q == ST_INIT) begin
            mem_q[ptr_q] <= XLEN'(init_val(INIT_MODE, int'(ptr_q)));
        end else begin
            if (wa_ok) begin
                mem_q[wa_addr_i] <= wa_data_i;
            end
            if (wb_ok) begin
                mem_q[wb_addr_i] <= wb_data_i;
            end
        end
    end

    rf_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .clr_a_en_i   (wa_ok),
        .clr_a_addr_i (wa_addr_i),
        .clr_b_en_i   (wb_ok),
        .clr_b_addr_i (wb_addr_i),
        .set_en_i     (iss_ok),
        .set_addr_i   (iss_addr_i),
        .busy_o       (busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rd_addr_i[k*AW +: AW];

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (ready && addr_ok(addr)) begin
                data = mem_q[addr];
                bsy  = busy[addr];
                if (BYPASS != 0) begin
                    if (wb_ok && wb_addr_i == addr) begin
                        data = wb_data_i;
                    end else if (wa_ok && wa_addr_i == addr) begin
                        data = wa_data_i;
                    end
                end
            end
        end

        assign rd_data_o[k*XLEN +: XLEN] = data;
        assign rd_busy_o[k]              = bsy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp (bypass and non-bypass instances)
module tb_reg_file_mp;

    logic        clock;
    logic        reset_n;
    logic [4:0]  ra0, ra1;
    logic [9:0]  rd_addr;
    logic        wa_en, wb_en, iss_en;
    logic [4:0]  wa_addr, wb_addr, iss_addr;
    logic [31:0] wa_data, wb_data;

    logic        ready, ready_nb;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic        collide, collide_nb;

    int checks = 0;
    int errors = 0;

    assign rd_addr = {ra1, ra0};

    reg_file_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .INIT_MODE(1), .BYPASS(1)) u_dut (
        .clock_i   (clock),     .reset_i   (reset_n),   .ready_o  (ready),
        .rd_addr_i (rd_addr),   .rd_data_o (rd_data),   .rd_busy_o(rd_busy),
        .wa_en_i   (wa_en),     .wa_addr_i (wa_addr),   .wa_data_i(wa_data),
        .wb_en_i   (wb_en),     .wb_addr_i (wb_addr),   .wb_data_i(wb_data),
        .iss_en_i  (iss_en),    .iss_addr_i(iss_addr),  .collide_o(collide)
    );

    reg_file_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .INIT_MODE(1), .BYPASS(0)) u_nb (
        .clock_i   (clock),     .reset_i   (reset_n),   .ready_o  (ready_nb),
        .rd_addr_i (rd_addr),   .rd_data_o (rd_data_nb),.rd_busy_o(rd_busy_nb),
        .wa_en_i   (wa_en),     .wa_addr_i (wa_addr),   .wa_data_i(wa_data),
        .wb_en_i   (wb_en),     .wb_addr_i (wb_addr),   .wb_data_i(wb_data),
        .iss_en_i  (iss_en),    .iss_addr_i(iss_addr),  .collide_o(collide_nb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        clear_in();
        wa_addr = '0; wb_addr = '0; iss_addr = '0;
        wa_data = '0; wb_data = '0;
        ra0 = 5'd25; ra1 = 5'd10;
        #12;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (collide !== 1'b0) begin errors++; $display("FAIL reset_collide got %b want 0", collide); end
        checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        wait_ready(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL sweep_cycles got %0d want 32", n); end
        #1;
        checks++; if (rd_data[31:0] !== 32'h25) begin errors++; $display("FAIL init_reg25 got %h want 00000025", rd_data[31:0]); end
        checks++; if (rd_data[63:32] !== 32'h10) begin errors++; $display("FAIL init_reg10 got %h want 00000010", rd_data[63:32]); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL init_busy got %b want 00", rd_busy); end
        ra0 = 5'd0; #1;
        checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL init_reg0 got %h want 0", rd_data[31:0]); end
    endtask

    task automatic test_bypass();
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        ra0 = 5'd5; #1;
        checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_same got %h want deadbeef", rd_data[31:0]); end
        checks++; if (rd_data_nb[31:0] !== 32'h05) begin errors++; $display("FAIL nobypass_same got %h want 00000005", rd_data_nb[31:0]); end
        tick();
        clear_in(); #1;
        checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_next got %h want deadbeef", rd_data[31:0]); end
        checks++; if (rd_data_nb[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL nobypass_next got %h want deadbeef", rd_data_nb[31:0]); end
    endtask

    task automatic test_collide();
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1111;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2222;
        ra0 = 5'd7; #1;
        checks++; if (rd_data[31:0] !== 32'h2222) begin errors++; $display("FAIL collide_bypass got %h want 00002222", rd_data[31:0]); end
        checks++; if (collide !== 1'b0) begin errors++; $display("FAIL collide_early got %b want 0", collide); end
        tick();
        clear_in(); #1;
        checks++; if (collide !== 1'b1) begin errors++; $display("FAIL collide_pulse got %b want 1", collide); end
        checks++; if (rd_data_nb[31:0] !== 32'h2222) begin errors++; $display("FAIL collide_store got %h want 00002222", rd_data_nb[31:0]); end
        tick();
        checks++; if (collide !== 1'b0) begin errors++; $display("FAIL collide_one_cycle got %b want 0", collide); end
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h3333;
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h4444;
        ra0 = 5'd7; ra1 = 5'd8;
        tick();
        clear_in(); #1;
        checks++; if (collide !== 1'b0) begin errors++; $display("FAIL nocollide got %b want 0", collide); end
        checks++; if (rd_data_nb[31:0] !== 32'h3333) begin errors++; $display("FAIL dual_wa got %h want 00003333", rd_data_nb[31:0]); end
        checks++; if (rd_data_nb[63:32] !== 32'h4444) begin errors++; $display("FAIL dual_wb got %h want 00004444", rd_data_nb[63:32]); end
    endtask

    task automatic test_zero();
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        ra0 = 5'd0; ra1 = 5'd0; #1;
        checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL zero_bypass got %h want 0", rd_data); end
        tick();
        clear_in(); #1;
        checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL zero_stored got %h want 0", rd_data); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL zero_busy got %b want 00", rd_busy); end
    endtask

    task automatic test_scoreboard();
        iss_en = 1'b1; iss_addr = 5'd12;
        ra0 = 5'd12; ra1 = 5'd3; #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL busy_not_bypassed got %b want 0", rd_busy[0]); end
        tick();
        clear_in(); #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL busy_set got %b want 1", rd_busy[0]); end
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hABCD;
        iss_en = 1'b1; iss_addr = 5'd12;
        tick();
        clear_in(); #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL busy_issue_wins got %b want 1", rd_busy[0]); end
        checks++; if (rd_data[31:0] !== 32'hABCD) begin errors++; $display("FAIL busy_wb_data got %h want 0000abcd", rd_data[31:0]); end
        wa_en = 1'b1; wa_addr = 5'd12; wa_data = 32'h5555; #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL busy_same_cycle got %b want 1", rd_busy[0]); end
        tick();
        clear_in(); #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL busy_clear got %b want 0", rd_busy[0]); end
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        clear_in(); #1;
        checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL busy_set3 got %b want 1", rd_busy[1]); end
    endtask

    task automatic test_mid_reset();
        int n;
        reset_n = 1'b0; #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_ready got %b want 0", ready); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL async_busy got %b want 00", rd_busy); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        iss_en = 1'b1; iss_addr = 5'd20;
        ra0 = 5'd25; ra1 = 5'd3;
        repeat (17) tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL sweep_ready got %b want 0", ready); end
        checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL sweep_rd_data got %h want 0", rd_data[31:0]); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b want 0", ready); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        wait_ready(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL restart_cycles got %0d want 32", n); end
        clear_in();
        ra0 = 5'd20; ra1 = 5'd3; #1;
        checks++; if (rd_data[31:0] !== 32'h20) begin errors++; $display("FAIL restart_reg20 got %h want 00000020", rd_data[31:0]); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL restart_busy got %b want 00", rd_busy); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collide();
        test_zero();
        test_scoreboard();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
